instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Instruction decoder: inverse of the set_instruction_{i,j,r} encoders. Takes 32-bit words from fetch,
//  splits fields, produces the control bundle consumed by the datapath, and holds them in one pipeline
//  register with valid/ready handshakes on both sides. Tracks MULTU/DIVU occupancy and stalls HI/LO hazards.
// PARAMETERS
//  MUL_LATENCY  4   cycles MULTU occupies the HI/LO unit after accept (>=1)
//  DIV_LATENCY  32  cycles DIVU occupies the HI/LO unit after accept (>=1)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  flush         in   1   kill the held instruction (branch/jump redirect)
//  in_valid      in   1   fetch presents in_instr/in_pc_plus4
//  in_ready      out  1   decoder accepts this cycle
//  in_instr      in   32  instruction word
//  in_pc_plus4   in   32  PC+4 of in_instr
//  out_valid     out  1   decoded bundle valid
//  out_ready     in   1   datapath consumes bundle
//  out_ctrl      out  CW  {rf_we, sel_wa, sel_alu_b, sel_result, sel_pc, branch, alu_ctrl}, global_types encodings
//  out_rs/out_rt/out_rd/out_shamt  out 5 each  instr[25:21]/[20:16]/[15:11]/[10:6]
//  out_sign_imm  out  32  sign-extended instr[15:0]
//  out_jaddr     out  26  instr[25:0]
//  out_pc_plus4  out  32  registered in_pc_plus4
//  out_illegal   out  1   unsupported opcode/funct
//  md_busy       out  1   HI/LO unit occupied (md_cnt != 0)
// BEHAVIOUR
//  Reset: out_valid=0, out_illegal=0, all out_* regs 0, md_cnt=0, md_busy=0; in_ready=0 while rst high.
//  Decode (op=instr[31:26], fn=instr[5:0]); row = control tuple incl. alu_ctrl:
//   op 23 LW  {EN,WA0,SIGN_IMM,RD,PC_PLUS4,0,ADD}   op 2B SW  {DIS,WA0,SIGN_IMM,ALU_OUT,PC_PLUS4,0,ADD}
//   op 08 ADDI{EN,WA0,SIGN_IMM,ALU_OUT,PC_PLUS4,0,ADDI}  op 04 BEQ {DIS,WA0,DMEM_WD,ALU_OUT,BRANCH,1,SUB}
//   op 02 J   {DIS,WA0,DMEM_WD,ALU_OUT,JUMP,0,DONT_CARE} op 03 JAL {EN,31,DMEM_WD,PC_PLUS4,JUMP,0,DONT_CARE}
//   op 00: fn 20 ADD,24 AND,25 OR,2A SLT,22 SUB,10 MFHI,12 MFLO -> {EN,WA1,DMEM_WD,ALU_OUT,PC_PLUS4,0,<op>};
//          fn 08 JR {DIS,WA1,DMEM_WD,ALU_OUT,RESULT,0,JR}; fn 1B DIVU / 19 MULTU {DIS,WA1,DMEM_WD,DONT_CARE,PC_PLUS4,0,<op>}
//   other op/fn: out_illegal=1, ctrl={DIS,WA0,DMEM_WD,DONT_CARE,PC_PLUS4,0,DONT_CARE} (no side effects).
//  Stall: hz = in_valid & md_cnt!=0 & (in is MFHI|MFLO|MULTU|DIVU).
//  in_ready = !rst & !flush & !hz & (!out_valid | out_ready)   (combinational).
//  accept = in_valid & in_ready: output regs load next edge, out_valid<=1. Latency 1 cycle.
//  Else if out_ready | flush: out_valid<=0. Else hold all outputs stable (no change while out_valid & !out_ready).
//  flush has priority over everything except rst: out_valid<=0, nothing accepted that cycle; md_cnt NOT cleared
//   (in-flight MULTU/DIVU completes).
//  md_cnt: on accept of MULTU load MUL_LATENCY, DIVU load DIV_LATENCY; else decrement when nonzero.
//   Counts every cycle regardless of out_ready. Width = $clog2(max(latencies)+1). Never wraps below 0.
//  Boundary: MFHI offered on cycle md_cnt==1 stalls; accepted the cycle md_cnt reads 0.
//  Simultaneous out_ready & accept: old bundle retires, new loads same edge (full throughput, no bubble).
//  Reset mid-stall / mid-divide: all state cleared next edge; pending MFHI must be re-presented.
// TESTING
//  1 ADD $3,$1,$2 (0x00221820), out_ready=1 -> out_valid next cycle, ctrl=TB_ADDc, rs=1 rt=2 rd=3.
//  2 ADDI $4,$0,-1 (0x2004FFFF) -> ctrl=TB_ADDIc, out_sign_imm=0xFFFFFFFF; JAL 0x0000010 -> sel_wa=31, jaddr=0x10.
//  3 MULTU then MFLO back-to-back, MUL_LATENCY=4 -> MFLO in_ready=0 for 4 cycles, accepted 4 cycles after MULTU accept.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* unchanged; streaming 8 ADDs with out_ready=1 -> 8 accepts in 8 cycles.
//  5 flush while out_valid=1 and DIVU in flight -> out_valid=0 next cycle, md_busy stays 1 until DIV_LATENCY elapses.
//  6 opcode 0x3F and R funct 0x3F -> out_illegal=1, rf_we=DISABLE; rst asserted mid-DIVU -> md_busy=0, out_valid=0 next edge.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: splits a fetched 32-bit word into its fields and
// builds the datapath control bundle. The result sits in a single pipeline
// register with valid/ready handshakes on both sides. A countdown tracks how
// long the HI/LO unit stays busy after MULTU/DIVU. Any HI/LO access (MFHI,
// MFLO, MULTU, DIVU) is stalled while that countdown is nonzero.
//
// Control bundle layout, MSB first (13 bits):
//   rf_we[12] sel_wa[11:10] sel_alu_b[9] sel_result[8:7] sel_pc[6:5]
//   branch[4] alu_ctrl[3:0]
module instr_decode_stage #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CW          = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc_plus4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [4:0]    out_rs,
    output logic [4:0]    out_rt,
    output logic [4:0]    out_rd,
    output logic [4:0]    out_shamt,
    output logic [31:0]   out_sign_imm,
    output logic [25:0]   out_jaddr,
    output logic [31:0]   out_pc_plus4,
    output logic          out_illegal,
    output logic          md_busy
);

    // rf_we
    localparam logic       EN  = 1'b1;
    localparam logic       DIS = 1'b0;
    // sel_wa: rt, rd, or the link register
    localparam logic [1:0] WA0  = 2'd0;
    localparam logic [1:0] WA1  = 2'd1;
    localparam logic [1:0] WA31 = 2'd2;
    // sel_alu_b
    localparam logic       B_DMEM_WD  = 1'b0;
    localparam logic       B_SIGN_IMM = 1'b1;
    // sel_result
    localparam logic [1:0] R_ALU_OUT  = 2'd0;
    localparam logic [1:0] R_RD       = 2'd1;
    localparam logic [1:0] R_PC_PLUS4 = 2'd2;
    localparam logic [1:0] R_DC       = 2'd3;
    // sel_pc
    localparam logic [1:0] P_PC_PLUS4 = 2'd0;
    localparam logic [1:0] P_BRANCH   = 2'd1;
    localparam logic [1:0] P_JUMP     = 2'd2;
    localparam logic [1:0] P_RESULT   = 2'd3;
    // alu_ctrl
    localparam logic [3:0] A_ADD   = 4'd0;
    localparam logic [3:0] A_SUB   = 4'd1;
    localparam logic [3:0] A_AND   = 4'd2;
    localparam logic [3:0] A_OR    = 4'd3;
    localparam logic [3:0] A_SLT   = 4'd4;
    localparam logic [3:0] A_ADDI  = 4'd5;
    localparam logic [3:0] A_MFHI  = 4'd6;
    localparam logic [3:0] A_MFLO  = 4'd7;
    localparam logic [3:0] A_JR    = 4'd8;
    localparam logic [3:0] A_MULTU = 4'd9;
    localparam logic [3:0] A_DIVU  = 4'd10;
    localparam logic [3:0] A_DC    = 4'd15;

    localparam int MAXLAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int MDW    = $clog2(MAXLAT + 1);

    logic [5:0]     op, fn;
    logic [CW-1:0]  dec_ctrl;
    logic           dec_illegal;
    logic           is_md, is_multu, is_divu;
    logic           hz, accept;
    logic [MDW-1:0] md_cnt;

    assign op = in_instr[31:26];
    assign fn = in_instr[5:0];

    // Decode the opcode/funct into a control tuple; unknown encodings fall back to a side-effect-free row
    always_comb begin
        dec_ctrl    = {DIS, WA0, B_DMEM_WD, R_DC, P_PC_PLUS4, 1'b0, A_DC};
        dec_illegal = 1'b1;
        is_multu    = 1'b0;
        is_divu     = 1'b0;
        is_md       = 1'b0;
        case (op)
            6'h23: begin dec_ctrl = {EN,  WA0,  B_SIGN_IMM, R_RD,       P_PC_PLUS4, 1'b0, A_ADD};  dec_illegal = 1'b0; end
            6'h2B: begin dec_ctrl = {DIS, WA0,  B_SIGN_IMM, R_ALU_OUT,  P_PC_PLUS4, 1'b0, A_ADD};  dec_illegal = 1'b0; end
            6'h08: begin dec_ctrl = {EN,  WA0,  B_SIGN_IMM, R_ALU_OUT,  P_PC_PLUS4, 1'b0, A_ADDI}; dec_illegal = 1'b0; end
            6'h04: begin dec_ctrl = {DIS, WA0,  B_DMEM_WD,  R_ALU_OUT,  P_BRANCH,   1'b1, A_SUB};  dec_illegal = 1'b0; end
            6'h02: begin dec_ctrl = {DIS, WA0,  B_DMEM_WD,  R_ALU_OUT,  P_JUMP,     1'b0, A_DC};   dec_illegal = 1'b0; end
            6'h03: begin dec_ctrl = {EN,  WA31, B_DMEM_WD,  R_PC_PLUS4, P_JUMP,     1'b0, A_DC};   dec_illegal = 1'b0; end
            6'h00: begin
                case (fn)
                    6'h20: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_ADD};  dec_illegal = 1'b0; end
                    6'h24: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_AND};  dec_illegal = 1'b0; end
                    6'h25: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_OR};   dec_illegal = 1'b0; end
                    6'h2A: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_SLT};  dec_illegal = 1'b0; end
                    6'h22: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_SUB};  dec_illegal = 1'b0; end
                    6'h10: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_MFHI}; dec_illegal = 1'b0; is_md = 1'b1; end
                    6'h12: begin dec_ctrl = {EN,  WA1, B_DMEM_WD, R_ALU_OUT, P_PC_PLUS4, 1'b0, A_MFLO}; dec_illegal = 1'b0; is_md = 1'b1; end
                    6'h08: begin dec_ctrl = {DIS, WA1, B_DMEM_WD, R_ALU_OUT, P_RESULT,   1'b0, A_JR};   dec_illegal = 1'b0; end
                    6'h1B: begin
                        dec_ctrl = {DIS, WA1, B_DMEM_WD, R_DC, P_PC_PLUS4, 1'b0, A_DIVU};
                        dec_illegal = 1'b0; is_md = 1'b1; is_divu = 1'b1;
                    end
                    6'h19: begin
                        dec_ctrl = {DIS, WA1, B_DMEM_WD, R_DC, P_PC_PLUS4, 1'b0, A_MULTU};
                        dec_illegal = 1'b0; is_md = 1'b1; is_multu = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign md_busy  = (md_cnt != '0);
    assign hz       = in_valid & md_busy & is_md;
    assign in_ready = !rst && !flush && !hz && (!out_valid || out_ready);
    assign accept   = in_valid & in_ready;

    // Pipeline register: load on accept, drop valid on consume or flush, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_ctrl     <= '0;
            out_rs       <= '0;
            out_rt       <= '0;
            out_rd       <= '0;
            out_shamt    <= '0;
            out_sign_imm <= '0;
            out_jaddr    <= '0;
            out_pc_plus4 <= '0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_ctrl     <= dec_ctrl;
            out_rs       <= in_instr[25:21];
            out_rt       <= in_instr[20:16];
            out_rd       <= in_instr[15:11];
            out_shamt    <= in_instr[10:6];
            out_sign_imm <= {{16{in_instr[15]}}, in_instr[15:0]};
            out_jaddr    <= in_instr[25:0];
            out_pc_plus4 <= in_pc_plus4;
            out_illegal  <= dec_illegal;
        end else if (out_ready || flush) begin
            out_valid    <= 1'b0;
        end
    end

    // HI/LO occupancy countdown; runs independently of the output handshake and survives flush
    always_ff @(posedge clk) begin
        if (rst)
            md_cnt <= '0;
        else if (accept && is_multu)
            md_cnt <= MDW'(MUL_LATENCY);
        else if (accept && is_divu)
            md_cnt <= MDW'(DIV_LATENCY);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a decode vector table streamed at
// full rate, followed by hand-written HI/LO stall, backpressure, flush and
// reset sequences.
module tb_instr_decode_stage;

    // Independent copy of the control encodings, bundle order
    // {rf_we, sel_wa[1:0], sel_alu_b, sel_result[1:0], sel_pc[1:0], branch, alu_ctrl[3:0]}
    localparam logic [12:0] C_ADD   = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0};
    localparam logic [12:0] C_AND   = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd2};
    localparam logic [12:0] C_OR    = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd3};
    localparam logic [12:0] C_SLT   = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd4};
    localparam logic [12:0] C_SUB   = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd1};
    localparam logic [12:0] C_MFHI  = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd6};
    localparam logic [12:0] C_MFLO  = {1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd7};
    localparam logic [12:0] C_JR    = {1'b0, 2'd1, 1'b0, 2'd0, 2'd3, 1'b0, 4'd8};
    localparam logic [12:0] C_MULTU = {1'b0, 2'd1, 1'b0, 2'd3, 2'd0, 1'b0, 4'd9};
    localparam logic [12:0] C_DIVU  = {1'b0, 2'd1, 1'b0, 2'd3, 2'd0, 1'b0, 4'd10};
    localparam logic [12:0] C_LW    = {1'b1, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 4'd0};
    localparam logic [12:0] C_SW    = {1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 4'd0};
    localparam logic [12:0] C_ADDI  = {1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 4'd5};
    localparam logic [12:0] C_BEQ   = {1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 1'b1, 4'd1};
    localparam logic [12:0] C_J     = {1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 1'b0, 4'd15};
    localparam logic [12:0] C_JAL   = {1'b1, 2'd2, 1'b0, 2'd2, 2'd2, 1'b0, 4'd15};
    localparam logic [12:0] C_ILL   = {1'b0, 2'd0, 1'b0, 2'd3, 2'd0, 1'b0, 4'd15};

    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal, md_busy;
    logic [31:0] in_instr, in_pc_plus4, out_sign_imm, out_pc_plus4;
    logic [12:0] out_ctrl;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [25:0] out_jaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.MUL_LATENCY(4), .DIV_LATENCY(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_plus4(in_pc_plus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_sign_imm(out_sign_imm), .out_jaddr(out_jaddr),
        .out_pc_plus4(out_pc_plus4), .out_illegal(out_illegal), .md_busy(md_busy)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [12:0] ctrl;
        logic        ill;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm;
        logic [25:0] jaddr;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{"ADD",   32'h00221820, C_ADD,   1'b0, 5'd1,  5'd2,  5'd3,  5'd0,  32'h00001820, 26'h0221820};
        vt[1]  = '{"ADDI",  32'h2004FFFF, C_ADDI,  1'b0, 5'd0,  5'd4,  5'd31, 5'd31, 32'hFFFFFFFF, 26'h004FFFF};
        vt[2]  = '{"JAL",   32'h0C000010, C_JAL,   1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000010, 26'h0000010};
        vt[3]  = '{"LW",    32'h8CC50008, C_LW,    1'b0, 5'd6,  5'd5,  5'd0,  5'd0,  32'h00000008, 26'h0C50008};
        vt[4]  = '{"SW",    32'hAC47FFFC, C_SW,    1'b0, 5'd2,  5'd7,  5'd31, 5'd31, 32'hFFFFFFFC, 26'h047FFFC};
        vt[5]  = '{"BEQ",   32'h10220003, C_BEQ,   1'b0, 5'd1,  5'd2,  5'd0,  5'd0,  32'h00000003, 26'h0220003};
        vt[6]  = '{"J",     32'h08000100, C_J,     1'b0, 5'd0,  5'd0,  5'd0,  5'd4,  32'h00000100, 26'h0000100};
        vt[7]  = '{"AND",   32'h012A4024, C_AND,   1'b0, 5'd9,  5'd10, 5'd8,  5'd0,  32'h00004024, 26'h12A4024};
        vt[8]  = '{"OR",    32'h00430825, C_OR,    1'b0, 5'd2,  5'd3,  5'd1,  5'd0,  32'h00000825, 26'h0430825};
        vt[9]  = '{"SLT",   32'h00A6202A, C_SLT,   1'b0, 5'd5,  5'd6,  5'd4,  5'd0,  32'h0000202A, 26'h0A6202A};
        vt[10] = '{"SUB",   32'h01093822, C_SUB,   1'b0, 5'd8,  5'd9,  5'd7,  5'd0,  32'h00003822, 26'h1093822};
        vt[11] = '{"JR",    32'h03E00008, C_JR,    1'b0, 5'd31, 5'd0,  5'd0,  5'd0,  32'h00000008, 26'h3E00008};
        vt[12] = '{"MFHI",  32'h00001010, C_MFHI,  1'b0, 5'd0,  5'd0,  5'd2,  5'd0,  32'h00001010, 26'h0001010};
        vt[13] = '{"MFLO",  32'h00001812, C_MFLO,  1'b0, 5'd0,  5'd0,  5'd3,  5'd0,  32'h00001812, 26'h0001812};
        vt[14] = '{"OP3F",  32'hFC000000, C_ILL,   1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00000000, 26'h0000000};
        vt[15] = '{"FN3F",  32'h0000003F, C_ILL,   1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0000003F, 26'h000003F};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc_plus4 = '0;
        tick(); tick();

        // Reset state
        in_valid = 1'b1; in_instr = 32'h00221820;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ctrl", 32'(out_ctrl), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_illegal", 32'(out_illegal), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(out_valid), 0);

        // Decode table streamed back-to-back
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_instr = vt[i].instr; in_pc_plus4 = 32'h1000 + 32'(i * 4);
            #1;
            chk({vt[i].name, "_in_ready"}, 32'(in_ready), 1);
            tick();
            chk({vt[i].name, "_valid"}, 32'(out_valid), 1);
            chk({vt[i].name, "_ctrl"}, 32'(out_ctrl), 32'(vt[i].ctrl));
            chk({vt[i].name, "_illegal"}, 32'(out_illegal), 32'(vt[i].ill));
            chk({vt[i].name, "_rs"}, 32'(out_rs), 32'(vt[i].rs));
            chk({vt[i].name, "_rt"}, 32'(out_rt), 32'(vt[i].rt));
            chk({vt[i].name, "_rd"}, 32'(out_rd), 32'(vt[i].rd));
            chk({vt[i].name, "_shamt"}, 32'(out_shamt), 32'(vt[i].shamt));
            chk({vt[i].name, "_imm"}, out_sign_imm, vt[i].imm);
            chk({vt[i].name, "_jaddr"}, 32'(out_jaddr), 32'(vt[i].jaddr));
            chk({vt[i].name, "_pc4"}, out_pc_plus4, 32'h1000 + 32'(i * 4));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        // MULTU then MFLO: MFLO stalls exactly MUL_LATENCY cycles
        in_valid = 1'b1; in_instr = 32'h00220019;
        #1;
        chk("multu_in_ready", 32'(in_ready), 1);
        tick();
        chk("multu_ctrl", 32'(out_ctrl), 32'(C_MULTU));
        chk("multu_busy", 32'(md_busy), 1);
        in_instr = 32'h00001812;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("mflo_stall%0d", k), 32'(in_ready), 0);
            tick();
        end
        chk("mflo_release", 32'(in_ready), 1);
        chk("mflo_busy_clear", 32'(md_busy), 0);
        tick();
        chk("mflo_ctrl", 32'(out_ctrl), 32'(C_MFLO));
        chk("mflo_rd", 32'(out_rd), 3);

        // Backpressure: held bundle must not change for 3 cycles
        in_instr = 32'h00221820;
        tick();
        chk("bp_load", 32'(out_ctrl), 32'(C_ADD));
        out_ready = 1'b0; in_instr = 32'h01093822;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 0);
            tick();
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
            chk($sformatf("bp_ctrl%0d", k), 32'(out_ctrl), 32'(C_ADD));
            chk($sformatf("bp_rd%0d", k), 32'(out_rd), 3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(in_ready), 1);
        tick();
        chk("bp_resume_ctrl", 32'(out_ctrl), 32'(C_SUB));

        // Stream 8 ADDs with distinct rd, one accept per cycle
        begin
            int acc;
            acc = 0;
            for (int i = 0; i < 8; i++) begin
                in_instr = 32'h00220020 | (32'(i) << 11);
                #1;
                if (in_ready) acc++;
                tick();
                chk($sformatf("stream_rd%0d", i), 32'(out_rd), 32'(i));
            end
            chk("stream_accepts", 32'(acc), 8);
        end

        // Flush with valid bundle and DIVU in flight
        begin
            int cyc;
            in_instr = 32'h0022001B;
            tick();
            cyc = 1;
            chk("divu_ctrl", 32'(out_ctrl), 32'(C_DIVU));
            in_instr = 32'h00221820;
            tick(); cyc++;
            chk("pre_flush_valid", 32'(out_valid), 1);
            flush = 1'b1;
            #1;
            chk("flush_in_ready", 32'(in_ready), 0);
            tick(); cyc++;
            chk("flush_valid", 32'(out_valid), 0);
            chk("flush_md_busy", 32'(md_busy), 1);
            flush = 1'b0; in_valid = 1'b0;
            while (md_busy && cyc < 100) begin
                tick(); cyc++;
            end
            chk("divu_busy_cycles", 32'(cyc), DIV_LAT + 1);
        end

        // Reset mid-DIVU with a stalled MFHI; MFHI must be accepted immediately after
        in_valid = 1'b1; in_instr = 32'h0022001B;
        tick();
        in_instr = 32'h00001010;
        tick(); tick();
        #1;
        chk("midiv_stall", 32'(in_ready), 0);
        rst = 1'b1;
        tick();
        chk("midiv_busy", 32'(md_busy), 0);
        chk("midiv_valid", 32'(out_valid), 0);
        chk("midiv_ctrl", 32'(out_ctrl), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_mfhi_ready", 32'(in_ready), 1);
        tick();
        chk("post_rst_mfhi_ctrl", 32'(out_ctrl), 32'(C_MFHI));
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
